// File: rtl/pe_ctx_loader_pkg.sv
// Shared constants and FSM state encoding for the PE context loader.
package pe_ctx_loader_pkg;

  localparam int NUM_PE    = 4;
  localparam int CTX_DEPTH = 4;
  localparam int INST_W    = 48;

  // Loader FSM states, kept as plain constants for legacy tools.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/pe_ctx_loader_counter_bank.sv
// Per-PE context counters: one counter per PE tracking how many context
// words have been written into that PE's config buffer during this pass.
module pe_ctx_counter_bank #(
  parameter  int NUM_PE    = pe_ctx_loader_pkg::NUM_PE,
  parameter  int CTX_DEPTH = pe_ctx_loader_pkg::CTX_DEPTH,
  localparam int ID_W      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1,
  localparam int CNT_W     = $clog2(CTX_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             inc,
  input  logic [ID_W-1:0]  inc_id,
  input  logic [CNT_W-1:0] ctx_num,
  output logic             id_valid,
  output logic             sel_full,
  output logic             all_equal
);
  import pe_ctx_loader_pkg::*;

  localparam logic [ID_W:0] PE_LIM = (ID_W + 1)'(NUM_PE);

  logic [CNT_W-1:0] cnt [NUM_PE];

  // Counters clear on reset or at the start of a pass and never wrap;
  // the loader only increments a counter that is still below ctx_num.
  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      for (int i = 0; i < NUM_PE; i++) cnt[i] <= '0;
    end else if (inc) begin
      cnt[inc_id] <= cnt[inc_id] + CNT_W'(1);
    end
  end

  // Report whether the addressed PE exists and is already full, and
  // whether every PE has received exactly ctx_num words.
  always_comb begin
    id_valid  = ({1'b0, inc_id} < PE_LIM);
    sel_full  = 1'b0;
    all_equal = 1'b1;
    if (id_valid) sel_full = (cnt[inc_id] == ctx_num);
    for (int i = 0; i < NUM_PE; i++) begin
      if (cnt[i] != ctx_num) all_equal = 1'b0;
    end
  end

endmodule

// File: rtl/pe_ctx_loader.sv
// Context loader for a row of PEs: writes tagged context words into the
// addressed PE buffers, then broadcasts run for ctx_num cycles.
module pe_ctx_loader #(
  parameter  int NUM_PE    = pe_ctx_loader_pkg::NUM_PE,
  parameter  int CTX_DEPTH = pe_ctx_loader_pkg::CTX_DEPTH,
  parameter  int INST_W    = pe_ctx_loader_pkg::INST_W,
  localparam int ID_W      = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        ctx_num,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [INST_W-1:0] cfg_data,
  input  logic [ID_W-1:0]   cfg_pe_id,
  input  logic              cfg_last,
  output logic [INST_W-1:0] pe_inst,
  output logic [NUM_PE-1:0] pe_init,
  output logic              pe_run,
  output logic              busy,
  output logic              done,
  output logic              err
);
  import pe_ctx_loader_pkg::*;

  localparam int CNT_W = $clog2(CTX_DEPTH + 1);

  logic [1:0]        state;
  logic [2:0]        ctx_q;
  logic [2:0]        run_cnt;
  logic              last_seen;
  logic              hs;
  logic              accept;
  logic              ctx_bad;
  logic              cnt_clear;
  logic              id_valid;
  logic              sel_full;
  logic              all_equal;
  logic [NUM_PE-1:0] id_onehot;

  assign hs        = cfg_valid & cfg_ready;
  assign accept    = hs & id_valid & ~sel_full;
  assign cnt_clear = (state == ST_IDLE) & start;
  assign ctx_bad   = (ctx_num == 3'd0) || (int'(ctx_num) > CTX_DEPTH);
  assign id_onehot = NUM_PE'(1) << cfg_pe_id;

  pe_ctx_counter_bank #(
    .NUM_PE    (NUM_PE),
    .CTX_DEPTH (CTX_DEPTH)
  ) u_counters (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (cnt_clear),
    .inc       (accept),
    .inc_id    (cfg_pe_id),
    .ctx_num   (CNT_W'(ctx_q)),
    .id_valid  (id_valid),
    .sel_full  (sel_full),
    .all_equal (all_equal)
  );

  // Main FSM. The final-word decision is taken one cycle after the last
  // handshake so the counters already include that word; this also makes
  // the first run cycle follow the last init strobe directly.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      ctx_q     <= '0;
      run_cnt   <= '0;
      last_seen <= 1'b0;
      cfg_ready <= 1'b0;
      pe_inst   <= '0;
      pe_init   <= '0;
      pe_run    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      pe_init <= '0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            ctx_q     <= ctx_num;
            run_cnt   <= '0;
            last_seen <= 1'b0;
            if (ctx_bad) begin
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end else begin
              err       <= 1'b0;
              busy      <= 1'b1;
              cfg_ready <= 1'b1;
              state     <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          if (last_seen) begin
            if (all_equal) begin
              pe_run  <= 1'b1;
              run_cnt <= 3'd1;
              state   <= ST_RUN;
            end else begin
              err   <= 1'b1;
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= ST_DONE;
            end
          end else if (hs) begin
            if (accept) begin
              pe_inst <= cfg_data;
              pe_init <= id_onehot;
            end else begin
              err <= 1'b1;
            end
            if (cfg_last) begin
              cfg_ready <= 1'b0;
              last_seen <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (run_cnt == ctx_q) begin
            pe_run <= 1'b0;
            done   <= 1'b1;
            busy   <= 1'b0;
            state  <= ST_DONE;
          end else begin
            run_cnt <= run_cnt + 3'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_ctx_loader.sv
// Self-checking bench for pe_ctx_loader: a reference model predicts the
// init strobes and pass outcome; a monitor compares them as they appear.
module tb_pe_ctx_loader;
  import pe_ctx_loader_pkg::*;

  localparam int ID_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [2:0]        ctx_num;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [INST_W-1:0] cfg_data;
  logic [ID_W-1:0]   cfg_pe_id;
  logic              cfg_last;
  logic [INST_W-1:0] pe_inst;
  logic [NUM_PE-1:0] pe_init;
  logic              pe_run;
  logic              busy;
  logic              done;
  logic              err;

  typedef struct {
    int                id;
    logic [INST_W-1:0] data;
  } init_t;

  typedef struct {
    int run_len;
    int err;
  } pass_t;

  init_t             exp_init_q[$];
  pass_t             exp_pass_q[$];
  int                wid[$];
  logic [INST_W-1:0] wdata[$];

  int errors   = 0;
  int checks   = 0;
  int run_seen = 0;

  pe_ctx_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ctx_num   (ctx_num),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .cfg_pe_id (cfg_pe_id),
    .cfg_last  (cfg_last),
    .pe_inst   (pe_inst),
    .pe_init   (pe_init),
    .pe_run    (pe_run),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes init or signals done.
  always @(negedge clk) begin
    if (!rst_n) begin
      run_seen = 0;
    end else begin
      if (pe_init != '0) begin
        checkOutput("init_run_exclusive", 64'(pe_run), 64'(0));
        if (exp_init_q.size() == 0) begin
          checkOutput("unexpected_init", 64'(pe_init), 64'(0));
        end else begin
          init_t e;
          e = exp_init_q.pop_front();
          checkOutput("init_onehot", 64'(pe_init), 64'(NUM_PE'(1) << e.id));
          checkOutput("init_data", 64'(pe_inst), 64'(e.data));
        end
      end
      if (pe_run) run_seen++;
      if (done) begin
        if (exp_pass_q.size() == 0) begin
          checkOutput("unexpected_done", 64'(done), 64'(0));
        end else begin
          pass_t p;
          p = exp_pass_q.pop_front();
          checkOutput("run_cycles", 64'(run_seen), 64'(p.run_len));
          checkOutput("err_flag", 64'(err), 64'(p.err));
          checkOutput("busy_at_done", 64'(busy), 64'(0));
          checkOutput("inits_pending", 64'(exp_init_q.size()), 64'(0));
        end
        run_seen = 0;
      end
    end
  end

  // Reference model: predicts accepted words and the pass outcome from
  // the word list using simple per-PE occupancy counts.
  task automatic modelPass(input int ctx);
    int    cnt [NUM_PE];
    int    dropped;
    int    alleq;
    pass_t p;
    init_t e;
    if (ctx < 1 || ctx > CTX_DEPTH) begin
      p.run_len = 0;
      p.err     = 1;
      exp_pass_q.push_back(p);
      return;
    end
    for (int i = 0; i < NUM_PE; i++) cnt[i] = 0;
    dropped = 0;
    for (int i = 0; i < wid.size(); i++) begin
      if (wid[i] >= NUM_PE || cnt[wid[i]] == ctx) begin
        dropped = 1;
      end else begin
        e.id   = wid[i];
        e.data = wdata[i];
        exp_init_q.push_back(e);
        cnt[wid[i]]++;
      end
    end
    alleq = 1;
    for (int i = 0; i < NUM_PE; i++) if (cnt[i] != ctx) alleq = 0;
    p.run_len = alleq ? ctx : 0;
    p.err     = (dropped || !alleq) ? 1 : 0;
    exp_pass_q.push_back(p);
  endtask

  task automatic addWord(input int id);
    logic [63:0] r;
    r = {$urandom(), $urandom()};
    wid.push_back(id);
    wdata.push_back(INST_W'(r));
  endtask

  task automatic doStart(input int ctx);
    int good;
    good      = (ctx >= 1 && ctx <= CTX_DEPTH) ? 1 : 0;
    start     = 1'b1;
    ctx_num   = 3'(ctx);
    @(posedge clk);
    #1;
    start     = 1'b0;
    ctx_num   = 3'($urandom_range(0, 7));
    checkOutput("busy_after_start", 64'(busy), 64'(good));
    checkOutput("done_after_start", 64'(done), 64'(1 - good));
  endtask

  task automatic sendWord(input int id, input logic [INST_W-1:0] data, input bit last, input bit noise);
    bit got;
    got       = 1'b0;
    cfg_valid = 1'b1;
    cfg_pe_id = ID_W'(id);
    cfg_data  = data;
    cfg_last  = last;
    if (noise) begin
      start   = 1'b1;
      ctx_num = 3'($urandom_range(0, 7));
    end
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (cfg_ready) begin
        got = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    checkOutput("cfg_ready_timeout", 64'(got), 64'(1));
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
    cfg_last  = 1'b0;
    start     = 1'b0;
  endtask

  task automatic waitDone(input int bound, input bit noise);
    bit got;
    got = 1'b0;
    for (int n = 0; n < bound; n++) begin
      @(negedge clk);
      if (done) begin
        got = 1'b1;
        break;
      end
      if (noise && pe_run) begin
        #1;
        start   = 1'b1;
        ctx_num = 3'($urandom_range(0, 7));
        @(posedge clk);
        #1;
        start = 1'b0;
      end
    end
    checkOutput("done_timeout", 64'(got), 64'(1));
    @(posedge clk);
    #1;
  endtask

  // gapmode 0: back-to-back words, 1: valid toggles every cycle, 2: random gaps.
  task automatic applyStimulus(input int ctx, input int gapmode, input bit noise);
    int gap;
    modelPass(ctx);
    doStart(ctx);
    if (ctx >= 1 && ctx <= CTX_DEPTH) begin
      for (int i = 0; i < wid.size(); i++) begin
        sendWord(wid[i], wdata[i], (i == wid.size() - 1), noise && ($urandom_range(0, 2) == 0));
        gap = (gapmode == 1) ? 1 : (gapmode == 2) ? $urandom_range(0, 2) : 0;
        repeat (gap) begin
          @(posedge clk);
          #1;
        end
      end
    end
    waitDone(60, noise);
  endtask

  task automatic buildRoundRobin(input int ctx);
    wid.delete();
    wdata.delete();
    for (int c = 0; c < ctx; c++)
      for (int p = 0; p < NUM_PE; p++) addWord(p);
  endtask

  task automatic buildRandom(input int ctx);
    int ids[$];
    int j;
    int tmp;
    int mode;
    wid.delete();
    wdata.delete();
    for (int c = 0; c < ctx; c++)
      for (int p = 0; p < NUM_PE; p++) ids.push_back(p);
    for (int i = ids.size() - 1; i > 0; i--) begin
      j      = $urandom_range(0, i);
      tmp    = ids[i];
      ids[i] = ids[j];
      ids[j] = tmp;
    end
    mode = $urandom_range(0, 3);
    if (mode == 1) ids.delete($urandom_range(0, ids.size() - 1));
    if (mode == 2) ids.insert($urandom_range(0, ids.size() - 1), $urandom_range(0, NUM_PE - 1));
    foreach (ids[i]) addWord(ids[i]);
  endtask

  initial begin
    int rc;
    rst_n     = 1'b0;
    start     = 1'b0;
    ctx_num   = '0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    cfg_pe_id = '0;
    cfg_last  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_outputs", {7'b0, pe_inst, pe_init, pe_run, cfg_ready, busy, done, err}, 64'(0));
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] test 1: round-robin load, ctx_num=2");
    buildRoundRobin(2);
    applyStimulus(2, 0, 1'b0);

    $display("[TB] test 2: same load with toggling valid");
    buildRoundRobin(2);
    applyStimulus(2, 1, 1'b0);

    $display("[TB] test 3: duplicate id with ctx_num=1");
    wid.delete();
    wdata.delete();
    addWord(0);
    addWord(2);
    addWord(2);
    addWord(3);
    applyStimulus(1, 0, 1'b0);

    $display("[TB] test 4: illegal ctx_num values");
    wid.delete();
    wdata.delete();
    applyStimulus(0, 0, 1'b0);
    applyStimulus(5, 0, 1'b0);
    applyStimulus(7, 0, 1'b0);

    $display("[TB] test 5: reset during run, ctx_num=4");
    buildRoundRobin(4);
    modelPass(4);
    doStart(4);
    for (int i = 0; i < wid.size(); i++) sendWord(wid[i], wdata[i], (i == wid.size() - 1), 1'b0);
    rc = 0;
    for (int n = 0; n < 40 && rc < 3; n++) begin
      @(negedge clk);
      if (pe_run) rc++;
    end
    checkOutput("run_reached_third_cycle", 64'(rc), 64'(3));
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("reset_mid_run", {7'b0, pe_inst, pe_init, pe_run, cfg_ready, busy, done, err}, 64'(0));
    exp_init_q.delete();
    exp_pass_q.delete();
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("post_reset_quiet", {pe_init, pe_run, busy, done}, 64'(0));
    buildRoundRobin(3);
    applyStimulus(3, 2, 1'b0);

    $display("[TB] test 6: start pulses during load and run");
    buildRoundRobin(3);
    applyStimulus(3, 2, 1'b1);

    $display("[TB] randomized passes");
    for (int t = 0; t < 12; t++) begin
      rc = $urandom_range(1, CTX_DEPTH);
      buildRandom(rc);
      applyStimulus(rc, 2, ($urandom_range(0, 1) == 1));
    end

    repeat (4) @(posedge clk);
    #1;
    checkOutput("passes_pending", 64'(exp_pass_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
